stopwatch_mmss: RTL and testbench

Minutes:seconds stopwatch that consumes the one-cycle `Pulse` from the 1 Hz countdown timer, which sits directly upstream, and keeps a four-digit BCD elapsed time. It debounce-free synchronizes three push-button levels (start/stop, lap, clear) and runs a small control FSM. It drives the upstream timer's `Enable`/`Reset` and presents BCD digits to the seven-segment decoders downstream.

---
 rtl/stopwatch_mmss_if.sv | 33 +++
 rtl/stopwatch_mmss.sv | 137 +++++++++++++
 tb/tb_stopwatch_mmss.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_mmss_if.sv
// stopwatch_mmss_if -- signal bundle between the stopwatch and its environment.
//   Tick                         : one-cycle count pulse from the upstream 1 Hz timer
//   StartStop, Lap, Clear        : raw push-button levels (asynchronous)
//   SecOnes..MinTens             : displayed BCD digits
//   Running, TimerEnable         : run status / upstream timer enable
//   TimerReset, Rollover         : one-cycle status pulses
// master = environment side (drives buttons/Tick), slave = stopwatch side.
interface stopwatch_mmss_if;
  logic       Tick;
  logic       StartStop;
  logic       Lap;
  logic       Clear;
  logic [3:0] SecOnes;
  logic [3:0] SecTens;
  logic [3:0] MinOnes;
  logic [3:0] MinTens;
  logic       Running;
  logic       TimerEnable;
  logic       TimerReset;
  logic       Rollover;

  modport master (
    output Tick, StartStop, Lap, Clear,
    input  SecOnes, SecTens, MinOnes, MinTens,
    input  Running, TimerEnable, TimerReset, Rollover
  );

  modport slave (
    input  Tick, StartStop, Lap, Clear,
    output SecOnes, SecTens, MinOnes, MinTens,
    output Running, TimerEnable, TimerReset, Rollover
  );
endinterface

// File: rtl/stopwatch_mmss.sv
// stopwatch_mmss -- MM:SS stopwatch driven by the upstream 1 Hz timer pulse.
//   Clock : system clock
//   Reset : asynchronous active-high, clears all state
//   bus   : slave side of stopwatch_mmss_if (Tick, buttons in; digits, status out)
// Buttons are synchronized (2 flops) plus an edge flop; one event per press.
// Event priority within a cycle: Clear > StartStop > Lap.
module stopwatch_mmss #(
  parameter int MaxMinutes = 59  // 1..99
) (
  input  logic              Clock,
  input  logic              Reset,
  stopwatch_mmss_if.slave   bus
);

  localparam logic [3:0] MAX_MT = 4'(MaxMinutes / 10);
  localparam logic [3:0] MAX_MO = 4'(MaxMinutes % 10);

  typedef enum logic [1:0] {STOPPED = 2'd0, RUNNING = 2'd1, LAP = 2'd2} state_t;

  // button bit order: [0] StartStop, [1] Lap, [2] Clear
  logic [2:0] btn_raw, btn_evt;
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic       clr_evt, ss_evt, lap_evt;

  // digit order: [0] sec ones, [1] sec tens, [2] min ones, [3] min tens
  logic [3:0][3:0] cnt_q, cnt_d, snap_q, snap_d, cnt_inc, disp;
  logic            wrap, counting;

  state_t state_q, state_d;
  logic   treset_q, treset_d;
  logic   roll_q, roll_d;

  assign btn_raw = {bus.Clear, bus.Lap, bus.StartStop};
  assign btn_evt = sync2_q & ~sync3_q;
  assign clr_evt = btn_evt[2];
  assign ss_evt  = btn_evt[0] & ~btn_evt[2];
  assign lap_evt = btn_evt[1] & ~btn_evt[2] & ~btn_evt[0];

  // BCD increment with MaxMinutes:59 -> 00:00 wrap
  always_comb begin
    cnt_inc = cnt_q;
    wrap    = 1'b0;
    if (cnt_q[0] != 4'd9) begin
      cnt_inc[0] = cnt_q[0] + 4'd1;
    end else begin
      cnt_inc[0] = 4'd0;
      if (cnt_q[1] != 4'd5) begin
        cnt_inc[1] = cnt_q[1] + 4'd1;
      end else begin
        cnt_inc[1] = 4'd0;
        if (cnt_q[3] == MAX_MT && cnt_q[2] == MAX_MO) begin
          cnt_inc[3] = 4'd0;
          cnt_inc[2] = 4'd0;
          wrap       = 1'b1;
        end else if (cnt_q[2] != 4'd9) begin
          cnt_inc[2] = cnt_q[2] + 4'd1;
        end else begin
          cnt_inc[2] = 4'd0;
          cnt_inc[3] = cnt_q[3] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    treset_d = 1'b0;
    roll_d   = 1'b0;
    // Tick qualifies on the pre-transition state: a stop still counts it,
    // a start from STOPPED does not.
    counting = (state_q != STOPPED) && bus.Tick;
    if (clr_evt) begin
      state_d  = STOPPED;
      cnt_d    = '0;
      snap_d   = '0;
      treset_d = 1'b1;
    end else begin
      if (counting) begin
        cnt_d  = cnt_inc;
        roll_d = wrap;
      end
      case (state_q)
        STOPPED: if (ss_evt) state_d = RUNNING;
        RUNNING: begin
          if (ss_evt) state_d = STOPPED;
          else if (lap_evt) begin
            state_d = LAP;
            snap_d  = cnt_q;  // value before this edge's tick
          end
        end
        LAP: begin
          if (ss_evt)       state_d = STOPPED;
          else if (lap_evt) state_d = RUNNING;
        end
        default: state_d = STOPPED;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
      state_q  <= STOPPED;
      cnt_q    <= '0;
      snap_q   <= '0;
      treset_q <= 1'b0;
      roll_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      treset_q <= treset_d;
      roll_q   <= roll_d;
    end
  end

  assign disp            = (state_q == LAP) ? snap_q : cnt_q;
  assign bus.SecOnes     = disp[0];
  assign bus.SecTens     = disp[1];
  assign bus.MinOnes     = disp[2];
  assign bus.MinTens     = disp[3];
  assign bus.Running     = (state_q != STOPPED);
  assign bus.TimerEnable = (state_q != STOPPED);
  assign bus.TimerReset  = treset_q;
  assign bus.Rollover    = roll_q;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Bench for stopwatch_mmss: directed scenarios plus random buttons/ticks,
// compared every cycle against an elapsed-seconds model.
module tb_stopwatch_mmss;
  localparam int MAX_MIN = 2;
  localparam int PERIOD  = (MAX_MIN + 1) * 60;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  stopwatch_mmss_if bus();

  stopwatch_mmss #(.MaxMinutes(MAX_MIN)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int shown_time();
    return int'(bus.MinTens) * 1000 + int'(bus.MinOnes) * 100 +
           int'(bus.SecTens) * 10 + int'(bus.SecOnes);
  endfunction

  task automatic chk_time(input string name, input int mm, input int ss);
    chk(name, shown_time(), (mm / 10) * 1000 + (mm % 10) * 100 + (ss / 10) * 10 + ss % 10);
  endtask

  // ---------------- model: mode 0=stopped 1=running 2=lap, time in seconds
  int       m_mode, m_elapsed, m_snap, m_prev;
  bit       m_roll, m_trst;
  bit [2:0] m_ev;
  bit [2:0] lv_q[$];  // past sampled button levels, [0] = most recent edge

  always @(posedge Clock) begin
    if (Reset) begin
      m_mode = 0; m_elapsed = 0; m_snap = 0; m_roll = 0; m_trst = 0;
      lv_q = '{3'b000, 3'b000, 3'b000};
    end else begin
      // a level first seen at edge e acts at edge e+2
      m_ev = lv_q[1] & ~lv_q[2];
      lv_q.push_front({bus.Clear, bus.Lap, bus.StartStop});
      void'(lv_q.pop_back());
      m_roll = 0;
      m_trst = 0;
      if (m_ev[2]) begin
        m_elapsed = 0; m_snap = 0; m_mode = 0; m_trst = 1;
      end else begin
        m_prev = m_elapsed;
        if (m_mode != 0 && bus.Tick) begin
          m_elapsed = (m_elapsed + 1) % PERIOD;
          if (m_elapsed == 0) m_roll = 1;
        end
        if (m_ev[0]) m_mode = (m_mode == 0) ? 1 : 0;
        else if (m_ev[1]) begin
          if (m_mode == 1) begin m_mode = 2; m_snap = m_prev; end
          else if (m_mode == 2) m_mode = 1;
        end
      end
    end
  end

  int e_shown;
  always @(negedge Clock) begin
    if (Reset) begin
      chk("cmp_digits_rst", shown_time(), 0);
      chk("cmp_running_rst", int'(bus.Running), 0);
      chk("cmp_enable_rst", int'(bus.TimerEnable), 0);
      chk("cmp_treset_rst", int'(bus.TimerReset), 0);
      chk("cmp_roll_rst", int'(bus.Rollover), 0);
    end else begin
      e_shown = (m_mode == 2) ? m_snap : m_elapsed;
      chk("cmp_digits", shown_time(),
          ((e_shown / 60) / 10) * 1000 + ((e_shown / 60) % 10) * 100 +
          ((e_shown % 60) / 10) * 10 + (e_shown % 10));
      chk("cmp_running", int'(bus.Running), int'(m_mode != 0));
      chk("cmp_enable", int'(bus.TimerEnable), int'(m_mode != 0));
      chk("cmp_treset", int'(bus.TimerReset), int'(m_trst));
      chk("cmp_roll", int'(bus.Rollover), int'(m_roll));
    end
  end

  // ---------------- stimulus
  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic set_btn(input logic [2:0] m);
    bus.StartStop = m[0];
    bus.Lap       = m[1];
    bus.Clear     = m[2];
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge Clock); bus.Tick = 1'b1;
      @(negedge Clock); bus.Tick = 1'b0;
    end
  endtask

  task automatic press(input logic [2:0] m);
    @(negedge Clock); set_btn(m);
    cyc(3);
    set_btn(3'b000);
    cyc(3);
  endtask

  bit [2:0] lvl;
  int       rem[3];

  initial begin
    bus.Tick = 1'b0;
    set_btn(3'b000);
    Reset = 1'b1;
    cyc(3);
    Reset = 1'b0;
    cyc(2);
    chk_time("reset_digits", 0, 0);
    chk("reset_running", int'(bus.Running), 0);

    press(3'b001);
    ticks(75);
    chk_time("t75_digits", 1, 15);
    chk("t75_running", int'(bus.Running), 1);
    chk("t75_enable", int'(bus.TimerEnable), 1);

    ticks(104);
    chk_time("before_wrap", 2, 59);
    @(negedge Clock); bus.Tick = 1'b1;
    @(negedge Clock); bus.Tick = 1'b0;
    chk_time("wrap_digits", 0, 0);
    chk("wrap_rollover", int'(bus.Rollover), 1);
    cyc(1);
    chk("rollover_one_cycle", int'(bus.Rollover), 0);
    ticks(9);
    chk_time("after_wrap_9", 0, 9);

    ticks(1);
    press(3'b010);
    chk_time("lap_enter", 0, 10);
    ticks(5);
    chk_time("lap_hold", 0, 10);
    chk("lap_running", int'(bus.Running), 1);
    press(3'b010);
    chk_time("lap_exit_live", 0, 15);

    ticks(5);
    chk_time("at_20", 0, 20);
    @(negedge Clock); bus.StartStop = 1'b1;
    cyc(2);
    bus.Tick = 1'b1;            // lands on the stop edge
    cyc(1);
    bus.Tick = 1'b0;
    chk_time("stop_with_tick", 0, 21);
    chk("stop_running", int'(bus.Running), 0);
    cyc(2);
    set_btn(3'b000);
    cyc(2);
    ticks(5);
    chk_time("stopped_ignores_tick", 0, 21);

    press(3'b001);
    ticks(12);
    chk_time("at_33", 0, 33);
    @(negedge Clock); set_btn(3'b111);
    cyc(3);
    chk("clear_treset", int'(bus.TimerReset), 1);
    chk_time("clear_digits", 0, 0);
    chk("clear_running", int'(bus.Running), 0);
    cyc(1);
    chk("treset_one_cycle", int'(bus.TimerReset), 0);
    set_btn(3'b000);
    cyc(3);

    bus.StartStop = 1'b1;       // first sampled at next edge k
    cyc(2);
    chk("hold_k1", int'(bus.Running), 0);
    cyc(1);
    chk("hold_k2", int'(bus.Running), 1);
    cyc(97);
    chk("hold_stays", int'(bus.Running), 1);
    set_btn(3'b000);
    cyc(3);
    chk("hold_release", int'(bus.Running), 1);

    ticks(7);
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("async_digits", shown_time(), 0);
    chk("async_running", int'(bus.Running), 0);
    chk("async_enable", int'(bus.TimerEnable), 0);
    chk("async_treset", int'(bus.TimerReset), 0);
    chk("async_roll", int'(bus.Rollover), 0);
    cyc(3);
    Reset = 1'b0;
    cyc(2);
    chk_time("post_reset", 0, 0);

    // random phase: buttons held >= 2 cycles, Clear rare
    lvl = 3'b000;
    rem[0] = 5; rem[1] = 20; rem[2] = 300;
    for (int c = 0; c < 4000; c++) begin
      @(negedge Clock);
      bus.Tick = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = ~lvl[b];
          if (lvl[b]) rem[b] = $urandom_range(2, 5);
          else        rem[b] = (b == 2) ? $urandom_range(150, 400) : $urandom_range(10, 60);
        end else begin
          rem[b] = rem[b] - 1;
        end
      end
      set_btn(lvl);
    end
    bus.Tick = 1'b0;
    set_btn(3'b000);
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
